// File: rtl/phy_tx_nch.sv
// ---------------------------------------------------------------------------
// phy_tx_nch : multi-channel serial PHY transmitter
//
// Each frame carries NUM_CH slots of DATA_W bits. Slot c carries channel c,
// and every slot is sent MSB first. A slot with no valid data carries the
// COMMA idle symbol. After every enable, SYNC_FRAMES comma-only frames are
// sent before any data.
//
// Ports
//   clk_8f     : serial bit clock (rising edge)
//   reset      : asynchronous active-high reset
//   enable     : transmitter enable, acted on only at frame boundaries
//   data_in    : channel c at [c*DATA_W +: DATA_W]
//   valid_in   : per-channel valid
//   load       : high in the last cycle of a frame whose successor is ACTIVE;
//                data_in/valid_in are captured on the following rising edge
//   serial_out : serial bit stream
//   slot_ch    : channel that owns the bit on serial_out
//   slot_valid : bit on serial_out is valid data (not comma)
//   active     : transmitter is in the ACTIVE state
//
// Optional feature macro: PHY_TX_SCRAMBLE_EN
//   When defined, valid data bits are XORed with the MSB of a 7-bit LFSR
//   (x^7+x^6+1, seed 7'h7F). Comma slots are sent raw.
// ---------------------------------------------------------------------------
module phy_tx_nch #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] COMMA = DATA_W'(8'hBC),
  parameter int SYNC_FRAMES = 4
) (
  input  logic                                         clk_8f,
  input  logic                                         reset,
  input  logic                                         enable,
  input  logic [NUM_CH*DATA_W-1:0]                     data_in,
  input  logic [NUM_CH-1:0]                            valid_in,
  output logic                                         load,
  output logic                                         serial_out,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] slot_ch,
  output logic                                         slot_valid,
  output logic                                         active
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FW = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                      state;
  logic [BW-1:0]               bit_cnt;
  logic [SW-1:0]               slot_cnt;
  logic [FW-1:0]               frame_cnt;
  logic [NUM_CH*DATA_W-1:0]    hold_data;
  logic [NUM_CH-1:0]           hold_valid;

  logic [DATA_W-1:0]           cur_word;
  logic                        cur_valid;
  logic [BW-1:0]               bit_idx;
  logic                        out_bit;
  logic                        last_pos;
  logic                        last_frame;

`ifdef PHY_TX_SCRAMBLE_EN
  logic [6:0]                  lfsr;

  // Next LFSR state for x^7+x^6+1, shifting towards the MSB.
  function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
    return {cur[5:0], cur[6] ^ cur[5]};
  endfunction
`endif

  assign last_pos   = (bit_cnt == BW'(DATA_W - 1)) && (slot_cnt == SW'(NUM_CH - 1));
  assign last_frame = (frame_cnt == FW'(SYNC_FRAMES - 1));
  assign active     = (state == ST_ACTIVE);

  // load depends on the live enable so that an enable drop on the last
  // cycle of a frame suppresses the pulse together with the state change.
  assign load = last_pos && enable &&
                (((state == ST_SYNC) && last_frame) || (state == ST_ACTIVE));

  // Select the word for the current slot and the bit to transmit.
  always_comb begin
    cur_word  = COMMA;
    cur_valid = 1'b0;
    if ((state == ST_ACTIVE) && hold_valid[slot_cnt]) begin
      cur_word  = hold_data[int'(slot_cnt)*DATA_W +: DATA_W];
      cur_valid = 1'b1;
    end else begin
      cur_word  = COMMA;
      cur_valid = 1'b0;
    end
    bit_idx = BW'(DATA_W - 1) - bit_cnt;
`ifdef PHY_TX_SCRAMBLE_EN
    out_bit = cur_word[bit_idx] ^ (cur_valid & lfsr[6]);
`else
    out_bit = cur_word[bit_idx];
`endif
  end

  // Frame sequencer: state, counters, holding registers and serial outputs.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      frame_cnt  <= '0;
      hold_data  <= '0;
      hold_valid <= '0;
      serial_out <= 1'b0;
      slot_ch    <= '0;
      slot_valid <= 1'b0;
`ifdef PHY_TX_SCRAMBLE_EN
      lfsr       <= 7'h7F;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt    <= '0;
          slot_cnt   <= '0;
          frame_cnt  <= '0;
          serial_out <= 1'b0;
          slot_ch    <= '0;
          slot_valid <= 1'b0;
          if (enable) begin
            state <= ST_SYNC;
`ifdef PHY_TX_SCRAMBLE_EN
            lfsr  <= 7'h7F;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SYNC, ST_ACTIVE: begin
          serial_out <= out_bit;
          slot_ch    <= slot_cnt;
          slot_valid <= cur_valid;
`ifdef PHY_TX_SCRAMBLE_EN
          if (cur_valid) begin
            lfsr <= lfsr_next(lfsr);
          end
`endif
          // Position counters run continuously, wrapping with no gap.
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_cnt  <= '0;
            slot_cnt <= (slot_cnt == SW'(NUM_CH - 1)) ? '0 : slot_cnt + SW'(1);
          end else begin
            bit_cnt  <= bit_cnt + BW'(1);
          end
          if (load) begin
            hold_data  <= data_in;
            hold_valid <= valid_in;
          end
          // Frame boundary decisions; frames are never truncated.
          if (last_pos) begin
            if (!enable) begin
              state     <= ST_IDLE;
              frame_cnt <= '0;
            end else if (state == ST_SYNC) begin
              if (last_frame) begin
                state     <= ST_ACTIVE;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_tx_nch.sv
module tb_phy_tx_nch;

  logic        clk_8f = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] data_in;
  logic [1:0]  valid_in;
  logic        load;
  logic        serial_out;
  logic [0:0]  slot_ch;
  logic        slot_valid;
  logic        active;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  valid;
    logic [15:0] ser;    // expected raw serial bits, first bit at [15]
    logic [15:0] sv;     // expected slot_valid, first bit at [15]
    int          drop_j; // sample index at which enable is dropped (-1 none)
    int          reset_j;// sample index at which reset is asserted (-1 none)
    bit          last;   // no frame follows this one
  } vec_t;

  vec_t vec[7];
  logic [7:0] comma = 8'hBC;
  logic [6:0] tb_lfsr;

  phy_tx_nch dut (
    .clk_8f(clk_8f), .reset(reset), .enable(enable), .data_in(data_in),
    .valid_in(valid_in), .load(load), .serial_out(serial_out),
    .slot_ch(slot_ch), .slot_valid(slot_valid), .active(active)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_8f); @(negedge clk_8f);
      chk({tag, "_ser"}, 32'(serial_out), 32'd0);
      chk({tag, "_sv"},  32'(slot_valid), 32'd0);
      chk({tag, "_ch"},  32'(slot_ch),    32'd0);
      chk({tag, "_load"},32'(load),       32'd0);
      chk({tag, "_act"}, 32'(active),     32'd0);
    end
  endtask

  // Enable from IDLE and check the 4-frame comma preamble.
  task automatic run_sync(input bit drop_last);
    tb_lfsr = 7'h7F;
    enable = 1'b1;
    @(posedge clk_8f);
    for (int k = 0; k < 64; k++) begin
      @(posedge clk_8f); @(negedge clk_8f);
      chk("sync_ser", 32'(serial_out), 32'(comma[7 - (k % 8)]));
      chk("sync_ch",  32'(slot_ch),    32'((k % 16) / 8));
      chk("sync_sv",  32'(slot_valid), 32'd0);
      chk("sync_act", 32'(active),     32'((k == 63) && !drop_last));
      // A mid-frame enable glitch must be ignored.
      if (k == 20) enable = 1'b0;
      if (k == 25) enable = 1'b1;
      if (k == 62 && drop_last) begin
        enable = 1'b0;
        #1;
      end
      chk("sync_load", 32'(load), 32'((k == 62) && !drop_last));
    end
  endtask

  // Check one data frame; the capture edge of vec[i] has just happened.
  task automatic run_frame(input int i);
    logic exp_bit;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk_8f); @(negedge clk_8f);
      if (j == 0) begin
        data_in  = 16'($urandom);
        valid_in = 2'($urandom);
      end
      if (j == vec[i].reset_j) begin
        reset = 1'b1;
        #1;
        chk("rst_ser", 32'(serial_out), 32'd0);
        chk("rst_act", 32'(active),     32'd0);
        chk("rst_sv",  32'(slot_valid), 32'd0);
        break;
      end
      exp_bit = vec[i].ser[15 - j];
`ifdef PHY_TX_SCRAMBLE_EN
      if (vec[i].sv[15 - j]) begin
        exp_bit = exp_bit ^ tb_lfsr[6];
        tb_lfsr = {tb_lfsr[5:0], tb_lfsr[6] ^ tb_lfsr[5]};
      end
`endif
      chk("data_ser", 32'(serial_out), 32'(exp_bit));
      chk("data_sv",  32'(slot_valid), 32'(vec[i].sv[15 - j]));
      chk("data_ch",  32'(slot_ch),    32'(j / 8));
      chk("data_act", 32'(active),     32'(!((j == 15) && vec[i].last)));
      if (j == vec[i].drop_j) enable = 1'b0;
      if (j == 14) begin
        if (vec[i].last) begin
          enable = 1'b0;
        end else begin
          data_in  = vec[i + 1].data;
          valid_in = vec[i + 1].valid;
        end
        #1;
        chk("data_load", 32'(load), 32'(!vec[i].last));
      end
    end
  endtask

  initial begin
    vec[0] = '{16'hCCDD, 2'b11, 16'hDDCC, 16'hFFFF, -1, -1, 1'b0};
    vec[1] = '{16'h9900, 2'b10, 16'hBC99, 16'h00FF, -1, -1, 1'b0};
    vec[2] = '{16'h1234, 2'b01, 16'h34BC, 16'hFF00, -1, -1, 1'b0};
    vec[3] = '{16'hA55A, 2'b00, 16'hBCBC, 16'h0000, -1, -1, 1'b0};
    vec[4] = '{16'h0FF0, 2'b11, 16'hF00F, 16'hFFFF, -1, -1, 1'b1};
    vec[5] = '{16'h817E, 2'b11, 16'h7E81, 16'hFFFF,  4, -1, 1'b1};
    vec[6] = '{16'hC33C, 2'b11, 16'h3CC3, 16'hFFFF, -1,  9, 1'b1};

    reset = 1'b1; enable = 1'b1; data_in = '0; valid_in = '0;
    @(negedge clk_8f);
    chk("reset_ser",  32'(serial_out), 32'd0);
    chk("reset_load", 32'(load),       32'd0);
    chk("reset_act",  32'(active),     32'd0);
    idle_cycles(3, "rst_hold");
    reset = 1'b0; enable = 1'b0;
    idle_cycles(20, "idle");

    // Preamble followed by a run of data frames, ending with enable low.
    data_in = vec[0].data; valid_in = vec[0].valid;
    run_sync(1'b0);
    for (int i = 0; i <= 4; i++) run_frame(i);
    idle_cycles(4, "post_data");

    // Enable drop coinciding with the last sync frame.
    run_sync(1'b1);
    idle_cycles(3, "sync_drop");

    // Enable drop mid-frame: frame completes, then full preamble again.
    data_in = vec[5].data; valid_in = vec[5].valid;
    run_sync(1'b0);
    run_frame(5);
    idle_cycles(3, "mid_drop");

    // Reset in the middle of an ACTIVE frame.
    data_in = vec[6].data; valid_in = vec[6].valid;
    run_sync(1'b0);
    run_frame(6);
    idle_cycles(3, "rst_mid");
    @(negedge clk_8f);
    reset = 1'b0; enable = 1'b0;
    idle_cycles(10, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
